dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshakes between the core (master) and
// the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: store enables/replicated data,
// load extraction with sign/zero extension, and the misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_size_e  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [15:0] shifted;

  // Only the low halfword of the shifted word is ever needed for sub-word loads.
  always_comb begin
    shifted     = 16'(rword >> {addr_lo, 3'b000});
    byte_en     = '0;
    wdata_lanes = '0;
    rdata_ext   = '0;
    misaligned  = 1'b0;
    case (size)
      BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = is_unsigned ? {16'b0, shifted}
                                  : {{16{shifted[15]}}, shifted};
        misaligned  = addr_lo[0];
      end
      WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
        misaligned  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed wait states over valid/ready.
// Optional tohost MMIO word enabled by defining DMEM_TOHOST_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_responder_if.slave bus,
  output logic           tohost_valid,
  output logic [31:0]    tohost_data
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  if ({2'b00, TOHOST_ADDR[31:2]} < 32'(DEPTH_WORDS)) begin : g_tohost_overlap
    $error("TOHOST_ADDR lies inside the memory array");
  end

  dmem_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic             lat_we, lat_unsigned;
  dmem_size_e       lat_size;
  logic [31:0]      lat_addr, lat_wdata;

  logic             acc_we, acc_unsigned;
  dmem_size_e       acc_size;
  logic [31:0]      acc_addr, acc_wdata;

  logic             accept, commit, in_range, size_err, misaligned, access_err, do_write;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rword, rdata_ext, wdata_lanes, load_data;
  logic [3:0]       byte_en;

  assign accept = (state == IDLE) && bus.req_valid;
  assign commit = (state != RESP) && (state_nxt == RESP);

  // With zero wait states the access commits on the accepting edge, so the
  // live request fields are used instead of the not-yet-latched copies.
  assign acc_we       = (state == IDLE) ? bus.req_we                  : lat_we;
  assign acc_size     = (state == IDLE) ? dmem_size_e'(bus.req_size)  : lat_size;
  assign acc_unsigned = (state == IDLE) ? bus.req_unsigned            : lat_unsigned;
  assign acc_addr     = (state == IDLE) ? bus.req_addr                : lat_addr;
  assign acc_wdata    = (state == IDLE) ? bus.req_wdata               : lat_wdata;

  assign word_idx = acc_addr[IDX_W+1:2];
  assign in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign size_err = (acc_size == ILLEGAL);
  assign rword    = in_range ? mem[word_idx] : '0;

  dmem_lane_align u_lane_align (
    .size        (acc_size),
    .addr_lo     (acc_addr[1:0]),
    .is_unsigned (acc_unsigned),
    .wdata       (acc_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

`ifdef DMEM_TOHOST_EN
  logic is_tohost;

  assign is_tohost  = (acc_addr == TOHOST_ADDR);
  assign access_err = size_err | misaligned | (is_tohost ? (acc_size != WORD) : !in_range);
  assign load_data  = is_tohost ? tohost_data : rdata_ext;
  assign do_write   = commit & !access_err & acc_we & !is_tohost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (commit && !access_err && is_tohost && acc_we) begin
      tohost_valid <= 1'b1;
      tohost_data  <= acc_wdata;
    end
  end
`else
  assign access_err   = size_err | misaligned | !in_range;
  assign load_data    = rdata_ext;
  assign do_write     = commit & !access_err & acc_we;
  assign tohost_valid = 1'b0;
  assign tohost_data  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_size     <= BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (accept) begin
      cnt          <= CNT_W'(WAIT_STATES);
      lat_we       <= bus.req_we;
      lat_size     <= dmem_size_e'(bus.req_size);
      lat_unsigned <= bus.req_unsigned;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (commit) begin
      bus.rsp_err   <= access_err;
      bus.rsp_rdata <= (access_err || acc_we) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-array
// reference model; build with DMEM_TOHOST_EN to cover the tohost word.
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam int          WS     = 2;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int tests;
  int fails;

  logic [7:0]  model_mem [4*DEPTH];
  bit          th_valid;
  logic [31:0] th_data;

  logic [31:0] last_rdata;
  logic        last_err;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'h00;
    th_valid = 1'b0;
    th_data  = '0;
  endfunction

  // Reference behaviour from the access rules: bytes in, bytes out.
  function automatic void model_access(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int unsigned     nbytes;
    longint unsigned val;
    bit              is_th;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    is_th  = 1'b0;
`ifdef DMEM_TOHOST_EN
    is_th  = (addr == TOHOST);
`endif
    err = (size == 2'd3) || ((addr % nbytes) != 0) ||
          (!is_th && (addr >= 4*DEPTH)) || (is_th && (size != 2'd2));
    rdata = '0;
    if (!err) begin
      if (is_th) begin
        if (we) begin
          th_valid = 1'b1;
          th_data  = wdata;
        end else begin
          rdata = th_data;
        end
      end else if (we) begin
        for (int i = 0; i < int'(nbytes); i++) model_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < int'(nbytes); i++) val = val | (longint'(model_mem[addr + i]) << (8*i));
        if (!uns && nbytes < 4 && (((val >> (8*nbytes - 1)) & 1) != 0))
          val = val - (64'd1 << (8*nbytes));
        rdata = val[31:0];
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction: accept, latency, response data, optional stall, return to IDLE.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] held;
    int          lat;
    @(negedge clk);
    check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = (hold == 0);
    @(posedge clk);
    #1;
    model_access(we, size, uns, addr, wdata, exp_rdata, exp_err);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(WS + 1));
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    last_rdata = bus.rsp_rdata;
    last_err   = bus.rsp_err;
    held       = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, held);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    model_clear();
    #12;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_tohost_valid", 32'(tohost_valid), 32'd0);
    check("reset_tohost_data", tohost_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    check("sw_err", 32'(last_err), 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    check("lw_0x10", last_rdata, 32'hDEAD_BEEF);

    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h7F, 0);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    check("lb_0x13", last_rdata, 32'hFFFF_FFDE);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    check("lbu_0x13", last_rdata, 32'h0000_00DE);
    access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0);
    check("lh_0x10", last_rdata, 32'h0000_7FEF);

    access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0);
    check("lh_misaligned_err", 32'(last_err), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0);
    check("lw_misaligned_err", 32'(last_err), 32'd1);
    access(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    check("illegal_size_err", 32'(last_err), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0, 0);
    check("out_of_range_err", 32'(last_err), 32'd1);
    check("out_of_range_rdata", last_rdata, 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF, 0);
    check("sw_misaligned_err", 32'(last_err), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    check("lw_0x10_unchanged", last_rdata, 32'hDEAD_7FEF);

    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    // Reset arrives while the store is still waiting to commit.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    check("lw_0x20_after_reset", last_rdata, 32'd0);

    access(1'b1, 2'd2, 1'b0, TOHOST, 32'h1, 0);
`ifdef DMEM_TOHOST_EN
    check("tohost_store_err", 32'(last_err), 32'd0);
    check("tohost_valid_set", 32'(tohost_valid), 32'd1);
    check("tohost_data_set", tohost_data, 32'd1);
    access(1'b0, 2'd2, 1'b0, TOHOST, 32'h0, 0);
    check("tohost_load", last_rdata, 32'd1);
    access(1'b1, 2'd0, 1'b0, TOHOST, 32'h5, 0);
    check("tohost_byte_err", 32'(last_err), 32'd1);
`else
    check("tohost_store_err", 32'(last_err), 32'd1);
    check("tohost_valid_clear", 32'(tohost_valid), 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          pick;
      pick = $urandom_range(0, 11);
      if (pick == 0)      a = 32'(4*DEPTH) + 32'($urandom_range(0, 7));
      else if (pick == 1) a = $urandom;
      else if (pick == 2) a = TOHOST;
      else                a = 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      access(1'($urandom), sz, 1'($urandom), a, $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    check("final_tohost_valid", 32'(tohost_valid), 32'(th_valid));
    check("final_tohost_data", tohost_data, th_data);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
